// File: rtl/pow3_rr_sched_pkg.sv
// ============================================================================
// Module : pow3_rr_sched_pkg
// Brief  : Shared scheduler state encoding and default datapath widths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pow3_rr_sched_pkg;

    localparam int A_W_DEF = 8;
    localparam int Y_W_DEF = 24;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pow3_rr_sched_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic w_found;
    int   w_k;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_k      = 0;
        for (int i = 0; i < N; i++) begin
            w_k = (int'(i_ptr) + i) % N;
            if (!w_found && i_req[w_k]) begin
                w_found       = 1'b1;
                o_onehot[w_k] = 1'b1;
                o_idx         = IW'(w_k);
            end
        end
        o_any = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/pow3_rr_sched.sv
// ============================================================================
// Module : pow3_rr_sched
// Brief  : Round-robin sharing of one sequential cube unit with watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pow3_rr_sched
    import pow3_rr_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_W     = A_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int BUSY_TO = 4,
    parameter int DONE_TO = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*A_W-1:0] a_bi,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [N_REQ-1:0]     done_o,
    output logic [Y_W-1:0]       y_bo,
    output logic                 err_o,
    output logic                 u_start_o,
    output logic [A_W-1:0]       u_a_bo,
    input  logic                 u_busy_i,
    input  logic                 u_done_i,
    input  logic [Y_W-1:0]       u_y_bi
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(DONE_TO + 1);
    localparam logic [TW-1:0] C_BUSY_TO = TW'(BUSY_TO);
    localparam logic [TW-1:0] C_DONE_TO = TW'(DONE_TO);
    localparam logic [IW-1:0] C_LAST    = IW'(N_REQ - 1);

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_idx;
    logic [TW-1:0]      r_timer;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [Y_W-1:0]     r_y;
    logic               r_err;
    logic               r_start;
    logic [A_W-1:0]     r_a;

    logic [N_REQ-1:0]   w_pick_oh;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any;
    logic [N_REQ-1:0]   w_idx_oh;
    logic [TW-1:0]      w_timer_inc;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_idx_oh    = N_REQ'(1) << r_idx;
    // Watchdog timer saturates rather than wrapping.
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_a     <= '0;
        end else begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_idx   <= w_pick_idx;
                        r_a     <= a_bi[w_pick_idx*A_W +: A_W];
                        r_gnt   <= w_pick_oh;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_timer <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A unit fast enough to finish before showing busy is accepted.
                    if (u_done_i) begin
                        r_y     <= u_y_bi;
                        r_err   <= 1'b0;
                        r_done  <= w_idx_oh;
                        r_state <= S_RESP;
                    end else if (u_busy_i) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == C_BUSY_TO) begin
                        r_y     <= '0;
                        r_err   <= 1'b1;
                        r_done  <= w_idx_oh;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_WAIT_DONE: begin
                    if (u_done_i) begin
                        r_y     <= u_y_bi;
                        r_err   <= 1'b0;
                        r_done  <= w_idx_oh;
                        r_state <= S_RESP;
                    end else if (r_timer == C_DONE_TO) begin
                        r_y     <= '0;
                        r_err   <= 1'b1;
                        r_done  <= w_idx_oh;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_RESP: begin
                    r_ptr   <= (r_idx == C_LAST) ? '0 : r_idx + IW'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign done_o    = r_done;
    assign y_bo      = r_y;
    assign err_o     = r_err;
    assign u_start_o = r_start;
    assign u_a_bo    = r_a;

endmodule

`default_nettype wire
